// File: rtl/sequence_detector_mealy.sv
// sequence_detector_mealy
// Overlapping serial detector for the bit pattern 1011 on X, one bit per clock.
// M selects how the detect flag is formed:
//   M=0 (Mealy): Z is asserted combinationally while the final 1 is on X.
//   M=1 (Moore): Z is decoded from the state alone, one cycle after the final 1.
// Q exports the state register for debug.
//
//   state | Q   | meaning
//   ------+-----+---------------------------------------------
//   S0    | 000 | idle, no useful prefix seen
//   S1    | 001 | "1" seen
//   S2    | 010 | "10" seen
//   S3    | 011 | "101" seen
//   S4    | 100 | "1011" seen (reached only with M=1)
//   --    | 101, 110, 111 | illegal; recover to S0 with Z=0
module sequence_detector_mealy (
    input  logic       clk,
    input  logic       reset,
    input  logic       X,
    input  logic       M,
    output logic       Z,
    output logic [2:0] Q
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_t;

    state_t state_q;
    state_t state_d;

    // Next-state logic; the trailing 1 of a match is reused as the next prefix.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0: state_d = X ? S1 : S0;
            S1: state_d = X ? S1 : S2;
            S2: state_d = X ? S3 : S0;
            S3: begin
                if (!X) begin
                    state_d = S2;
                end else if (M) begin
                    state_d = S4;
                end else begin
                    state_d = S1;
                end
            end
            S4: state_d = X ? S1 : S2;
            default: state_d = S0;
        endcase
    end

    // Detect flag: mode is read every cycle, and the flag is held low during reset.
    always_comb begin
        Z = 1'b0;
        if (reset) begin
            if (M) begin
                Z = (state_q == S4);
            end else begin
                Z = (state_q == S3) && X;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign Q = state_q;

endmodule

// File: tb/tb_sequence_detector_mealy.sv
// Directed bench for sequence_detector_mealy.
module tb_sequence_detector_mealy;

    logic       clk;
    logic       reset;
    logic       X;
    logic       M;
    logic       Z;
    logic [2:0] Q;

    int n_checks;
    int n_fail;

    logic [43:0] stream;
    logic        mealy_z [0:44];
    logic        moore_z [0:44];

    sequence_detector_mealy dut (
        .clk   (clk),
        .reset (reset),
        .X     (X),
        .M     (M),
        .Z     (Z),
        .Q     (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one bit at the falling edge, check Z before the capturing edge,
    // then check Q after it.
    task automatic apply(input string tag, input logic m, input logic x,
                         input logic exp_z, input logic [2:0] exp_q);
        @(negedge clk);
        M = m;
        X = x;
        #1;
        chk({tag, "_z"}, int'(Z), int'(exp_z));
        @(posedge clk);
        #1;
        chk({tag, "_q"}, int'(Q), int'(exp_q));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_q", int'(Q), 0);
        chk("rst_z", int'(Z), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Independent model of the transition table.
    function automatic int model_next(input int s, input logic x, input logic m);
        case (s)
            0: return x ? 1 : 0;
            1: return x ? 1 : 2;
            2: return x ? 3 : 0;
            3: return x ? (m ? 4 : 1) : 2;
            4: return x ? 1 : 2;
            default: return 0;
        endcase
    endfunction

    task automatic run_stream(input logic m);
        int   ms;
        logic xb;
        logic ez;
        pulse_reset();
        ms = 0;
        for (int i = 0; i < 45; i++) begin
            xb = (i < 44) ? stream[43 - i] : 1'b0;
            ez = m ? (ms == 4) : ((ms == 3) && xb);
            @(negedge clk);
            M = m;
            X = xb;
            #1;
            if (m) moore_z[i] = Z;
            else   mealy_z[i] = Z;
            chk(m ? "stream_moore_z" : "stream_mealy_z", int'(Z), int'(ez));
            ms = model_next(ms, xb, m);
            @(posedge clk);
            #1;
            chk(m ? "stream_moore_q" : "stream_mealy_q", int'(Q), ms);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c_mealy;
        int c_moore;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        X        = 1'b0;
        M        = 1'b0;
        stream   = 44'b01100010101101011011111001011011011011101010;

        repeat (2) @(posedge clk);
        #1;
        chk("init_q", int'(Q), 0);
        chk("init_z", int'(Z), 0);
        @(negedge clk);
        reset = 1'b1;

        // Mealy basic plus overlap: 1011011 -> pulses on bits 4 and 7
        apply("mealy_b1", 1'b0, 1'b1, 1'b0, 3'b001);
        apply("mealy_b2", 1'b0, 1'b0, 1'b0, 3'b010);
        apply("mealy_b3", 1'b0, 1'b1, 1'b0, 3'b011);
        apply("mealy_b4", 1'b0, 1'b1, 1'b1, 3'b001);
        apply("mealy_b5", 1'b0, 1'b0, 1'b0, 3'b010);
        apply("mealy_b6", 1'b0, 1'b1, 1'b0, 3'b011);
        apply("mealy_b7", 1'b0, 1'b1, 1'b1, 3'b001);

        // 1010 and 1001 give no pulse
        pulse_reset();
        apply("n1010_1", 1'b0, 1'b1, 1'b0, 3'b001);
        apply("n1010_2", 1'b0, 1'b0, 1'b0, 3'b010);
        apply("n1010_3", 1'b0, 1'b1, 1'b0, 3'b011);
        apply("n1010_4", 1'b0, 1'b0, 1'b0, 3'b010);
        pulse_reset();
        apply("n1001_1", 1'b0, 1'b1, 1'b0, 3'b001);
        apply("n1001_2", 1'b0, 1'b0, 1'b0, 3'b010);
        apply("n1001_3", 1'b0, 1'b0, 1'b0, 3'b000);
        apply("n1001_4", 1'b0, 1'b1, 1'b0, 3'b001);

        // Reset mid-pattern after 101 with X=1 held: Z stays low, Q clears
        pulse_reset();
        apply("midrst_1", 1'b0, 1'b1, 1'b0, 3'b001);
        apply("midrst_2", 1'b0, 1'b0, 1'b0, 3'b010);
        apply("midrst_3", 1'b0, 1'b1, 1'b0, 3'b011);
        @(negedge clk);
        reset = 1'b0;
        X     = 1'b1;
        #1;
        chk("midrst_z_in_reset", int'(Z), 0);
        @(posedge clk);
        #1;
        chk("midrst_q", int'(Q), 0);
        @(negedge clk);
        reset = 1'b1;
        apply("midrst_after", 1'b0, 1'b1, 1'b0, 3'b001);

        // Moore basic and overlap
        pulse_reset();
        apply("moore_b1", 1'b1, 1'b1, 1'b0, 3'b001);
        apply("moore_b2", 1'b1, 1'b0, 1'b0, 3'b010);
        apply("moore_b3", 1'b1, 1'b1, 1'b0, 3'b011);
        apply("moore_b4", 1'b1, 1'b1, 1'b0, 3'b100);
        chk("moore_hit1_z", int'(Z), 1);
        apply("moore_b5", 1'b1, 1'b0, 1'b1, 3'b010);
        chk("moore_hit1_end_z", int'(Z), 0);
        apply("moore_b6", 1'b1, 1'b1, 1'b0, 3'b011);
        apply("moore_b7", 1'b1, 1'b1, 1'b0, 3'b100);
        chk("moore_hit2_z", int'(Z), 1);

        // Mode switch while in S4: Z drops at once, S4 leaves on X=0 to S2
        apply("mswitch", 1'b0, 1'b0, 1'b0, 3'b010);

        // Long stream in both modes against the model
        run_stream(1'b0);
        run_stream(1'b1);
        c_mealy = 0;
        c_moore = 0;
        for (int i = 0; i < 45; i++) begin
            if (mealy_z[i]) c_mealy++;
            if (moore_z[i]) c_moore++;
        end
        chk("stream_mealy_count", c_mealy, 7);
        chk("stream_moore_count", c_moore, 7);
        chk("stream_moore_first_z", int'(moore_z[0]), 0);
        for (int i = 0; i < 44; i++) begin
            chk("stream_align", int'(moore_z[i + 1]), int'(mealy_z[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
